// File: rtl/phase_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | phase_sequencer: registered 0..LAST phase stepper driving a 4-to-16      |
// | decoder select/enable, with pause, abort and completed-pass count. r1.0  |
// +--------------------------------------------------------------------------+
module phase_sequencer #(
  parameter int unsigned LAST = 15
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  input  logic       loop,
  output logic [3:0] sel,
  output logic       en,
  output logic       busy,
  output logic       done,
  output logic       wrap,
  output logic [7:0] passes
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_SEL = 4'(LAST);

  state_t     state_q, state_d;
  logic [3:0] sel_q, sel_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wrap_q, wrap_d;
  logic [7:0] passes_q, passes_d;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    passes_d = passes_q;

    unique case (state_q)
      IDLE: begin
        sel_d = 4'd0;
        if (!clr && !stop && start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (clr) begin
          state_d = IDLE;
          sel_d   = 4'd0;
        end else if (stop) begin
          // The interrupted phase is not completed; it is re-presented on resume.
          state_d = PAUSE;
        end else if (sel_q == LAST_SEL) begin
          sel_d    = 4'd0;
          passes_d = passes_q + 8'd1;
          if (loop) begin
            wrap_d = 1'b1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          sel_d = sel_q + 4'd1;
        end
      end

      PAUSE: begin
        if (clr) begin
          state_d = IDLE;
          sel_d   = 4'd0;
        end else if (!stop && start) begin
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = 4'd0;
      end
    endcase

    en_d   = (state_d == RUN);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= IDLE;
      sel_q    <= 4'd0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      passes_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      passes_q <= passes_d;
    end
  end

  assign sel    = sel_q;
  assign en     = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;
  assign passes = passes_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// Bench for phase_sequencer: three instances (LAST=15, 5, 0) share stimulus and
// are compared every cycle against a rule-level model plus directed spot checks.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic reset_b, start, stop, clr, loop;

  logic [3:0] d_sel    [3];
  logic       d_en     [3];
  logic       d_busy   [3];
  logic       d_done   [3];
  logic       d_wrap   [3];
  logic [7:0] d_passes [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.LAST(15)) u15 (
    .clk(clk), .reset_b(reset_b), .start(start), .stop(stop), .clr(clr), .loop(loop),
    .sel(d_sel[0]), .en(d_en[0]), .busy(d_busy[0]), .done(d_done[0]),
    .wrap(d_wrap[0]), .passes(d_passes[0])
  );

  phase_sequencer #(.LAST(5)) u5 (
    .clk(clk), .reset_b(reset_b), .start(start), .stop(stop), .clr(clr), .loop(loop),
    .sel(d_sel[1]), .en(d_en[1]), .busy(d_busy[1]), .done(d_done[1]),
    .wrap(d_wrap[1]), .passes(d_passes[1])
  );

  phase_sequencer #(.LAST(0)) u0 (
    .clk(clk), .reset_b(reset_b), .start(start), .stop(stop), .clr(clr), .loop(loop),
    .sel(d_sel[2]), .en(d_en[2]), .busy(d_busy[2]), .done(d_done[2]),
    .wrap(d_wrap[2]), .passes(d_passes[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: mode is 0=idle, 1=running, 2=paused.
  int lasts [3] = '{15, 5, 0};
  int m_mode [3];
  int m_sel [3];
  int m_done [3];
  int m_wrap [3];
  int m_passes [3];

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int i = 0; i < 3; i++) begin
        m_mode[i] = 0; m_sel[i] = 0; m_done[i] = 0; m_wrap[i] = 0; m_passes[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        m_done[i] = 0;
        m_wrap[i] = 0;
        if (clr) begin
          m_mode[i] = 0;
          m_sel[i]  = 0;
        end else if (stop) begin
          if (m_mode[i] == 1) m_mode[i] = 2;
        end else if (m_mode[i] == 1) begin
          if (m_sel[i] == lasts[i]) begin
            m_sel[i]    = 0;
            m_passes[i] = (m_passes[i] + 1) % 256;
            if (loop) m_wrap[i] = 1;
            else begin
              m_done[i] = 1;
              m_mode[i] = 0;
            end
          end else begin
            m_sel[i] = m_sel[i] + 1;
          end
        end else if (start) begin
          if (m_mode[i] == 0) m_sel[i] = 0;
          m_mode[i] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model u%0d sel", lasts[i]), d_sel[i], m_sel[i]);
      chk($sformatf("model u%0d en", lasts[i]), d_en[i], (m_mode[i] == 1) ? 1 : 0);
      chk($sformatf("model u%0d busy", lasts[i]), d_busy[i], (m_mode[i] != 0) ? 1 : 0);
      chk($sformatf("model u%0d done", lasts[i]), d_done[i], m_done[i]);
      chk($sformatf("model u%0d wrap", lasts[i]), d_wrap[i], m_wrap[i]);
      chk($sformatf("model u%0d passes", lasts[i]), d_passes[i], m_passes[i]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    start = 0; stop = 0; clr = 0; loop = 0; reset_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset sel", d_sel[0], 0);
    chk("reset busy", d_busy[0], 0);
    chk("reset passes", d_passes[0], 0);
    reset_b = 1;
    cyc(2);

    // Single pass, LAST=15
    start = 1; cyc(1); start = 0;
    chk("s1 first sel", d_sel[0], 0);
    chk("s1 first en", d_en[0], 1);
    for (int k = 1; k <= 15; k++) begin
      cyc(1);
      chk("s1 step sel", d_sel[0], k);
      chk("s1 step en", d_en[0], 1);
    end
    cyc(1);
    chk("s1 done", d_done[0], 1);
    chk("s1 busy", d_busy[0], 0);
    chk("s1 en off", d_en[0], 0);
    chk("s1 passes", d_passes[0], 1);
    cyc(1);
    chk("s1 done one cycle", d_done[0], 0);

    // Loop mode, LAST=5
    loop = 1;
    start = 1; cyc(1); start = 0;
    chk("s2 u5 sel start", d_sel[1], 0);
    chk("s2 u5 wrap start", d_wrap[1], 0);
    for (int k = 2; k <= 19; k++) begin
      cyc(1);
      chk("s2 u5 sel", d_sel[1], (k - 1) % 6);
      chk("s2 u5 wrap", d_wrap[1], ((k - 1) % 6 == 0) ? 1 : 0);
    end
    chk("s2 u5 passes", d_passes[1], 4);
    chk("s2 u15 passes", d_passes[0], 2);
    clr = 1; cyc(1); clr = 0;
    chk("s2 clr busy", d_busy[0], 0);
    chk("s2 clr sel", d_sel[0], 0);
    chk("s2 clr done", d_done[0], 0);
    chk("s2 clr passes", d_passes[0], 2);
    loop = 0;
    cyc(1);

    // Pause and resume at sel=7
    start = 1; cyc(1); start = 0;
    cyc(7);
    chk("s3 sel7", d_sel[0], 7);
    stop = 1; cyc(1); stop = 0;
    chk("s3 paused sel", d_sel[0], 7);
    chk("s3 paused en", d_en[0], 0);
    chk("s3 paused busy", d_busy[0], 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("s3 hold sel", d_sel[0], 7);
      chk("s3 hold en", d_en[0], 0);
    end
    start = 1; cyc(1); start = 0;
    chk("s3 resume sel", d_sel[0], 7);
    chk("s3 resume en", d_en[0], 1);
    cyc(1);
    chk("s3 advance", d_sel[0], 8);
    cyc(7);
    chk("s3 last", d_sel[0], 15);
    cyc(1);
    chk("s3 done", d_done[0], 1);
    chk("s3 passes", d_passes[0], 3);
    cyc(1);

    // Simultaneous inputs at sel=3
    start = 1; cyc(1); start = 0;
    cyc(3);
    chk("s4 sel3", d_sel[0], 3);
    clr = 1; stop = 1; start = 1; cyc(1); clr = 0; stop = 0; start = 0;
    chk("s4 abort sel", d_sel[0], 0);
    chk("s4 abort en", d_en[0], 0);
    chk("s4 abort busy", d_busy[0], 0);
    chk("s4 abort done", d_done[0], 0);
    chk("s4 abort passes", d_passes[0], 3);
    cyc(1);
    chk("s4 no late done", d_done[0], 0);
    start = 1; cyc(1); start = 0;
    cyc(3);
    stop = 1; start = 1; cyc(1); stop = 0; start = 0;
    chk("s4 pause busy", d_busy[0], 1);
    chk("s4 pause en", d_en[0], 0);
    chk("s4 pause sel", d_sel[0], 3);
    cyc(1);
    clr = 1; cyc(1); clr = 0;
    cyc(1);

    // Asynchronous reset between edges at sel=9
    start = 1; cyc(1); start = 0;
    cyc(9);
    chk("s5 sel9", d_sel[0], 9);
    #3 reset_b = 0;
    #1;
    chk("s5 async sel", d_sel[0], 0);
    chk("s5 async en", d_en[0], 0);
    chk("s5 async busy", d_busy[0], 0);
    chk("s5 async passes", d_passes[0], 0);
    cyc(2);
    reset_b = 1;
    cyc(1);
    start = 1; cyc(1); start = 0;
    chk("s5 restart sel", d_sel[0], 0);
    chk("s5 restart en", d_en[0], 1);

    // LAST=0 single pass
    chk("s6 u0 sel", d_sel[2], 0);
    chk("s6 u0 en", d_en[2], 1);
    chk("s6 u0 no done yet", d_done[2], 0);
    cyc(1);
    chk("s6 u0 done", d_done[2], 1);
    chk("s6 u0 en off", d_en[2], 0);
    chk("s6 u0 busy", d_busy[2], 0);
    cyc(20);

    // LAST=0 looping: wrap every cycle after the first
    loop = 1;
    start = 1; cyc(1); start = 0;
    chk("s6 u0 loop first wrap", d_wrap[2], 0);
    chk("s6 u0 loop en", d_en[2], 1);
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("s6 u0 wrap", d_wrap[2], 1);
      chk("s6 u0 loop sel", d_sel[2], 0);
      chk("s6 u0 loop en", d_en[2], 1);
    end
    clr = 1; cyc(1); clr = 0;
    loop = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
